number_catcher: RTL and testbench
=================================

# number_catcher

- Game controller at the consuming end of the tick counter.
- Consumes the 0..100 `current_number` stream and drives the counter's `clk_speed` select back to it.
- Player presses `catch_n` to freeze the counter value. The block judges it against a switch-set target within a tolerance, keeps score over a fixed number of rounds, and speeds up the counter on each hit.

## Interface
Parameters:
- `NUM_W`, 7: width of counter value and target.
- `MAX_NUM`, 100: highest counter value; targets clamp to it.
- `TOL`, 2: inclusive hit tolerance |captured − target|.
- `ROUNDS`, 8: rounds per game, 1..15.
- `DEBOUNCE_CYCLES`, 250000: stable cycles required when debounce is compiled in.

Ports:
- `CLOCK_50` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `catch_n` in 1: raw active-low push button; asynchronous to `CLOCK_50`.
- `target` in NUM_W: switch-set target value.
- `current_number` in NUM_W: live counter value.
- `clk_speed` out 3: speed select returned to the counter.
- `captured` out NUM_W: last caught value.
- `score` out 4: hits this game.
- `round` out 4: rounds completed this game.
- `hit` out 1: one-cycle pulse on a judged hit.
- `miss` out 1: one-cycle pulse on a judged miss.
- `game_over` out 1: level; high once `ROUNDS` rounds are complete.

## Operation
- Press detection:
  - `catch_n` passes through a 2-flop synchronizer.
  - A falling edge of the synchronized level gives a one-cycle `press` pulse.
- FSM states and transitions:
  - IDLE: wait for `press` → RUN. Clear `score`, `round` and level.
  - RUN: on the `press` cycle, do `captured <= current_number` and `tgt_q <= min(target, MAX_NUM)` → JUDGE.
  - JUDGE (exactly 1 cycle): compute `dist` = larger − smaller of `captured` and `tgt_q`, unsigned NUM_W, no modular wrap (100 and 0 are distance 100).
    - `dist <= TOL`: hit. Pulse `hit`, `score += 1`, level = min(level+1, 2).
    - Otherwise: miss. Pulse `miss`, level unchanged.
    - Always `round += 1`.
    - New `round == ROUNDS` → OVER; else → COOLDOWN.
  - COOLDOWN: wait until the synchronized (or debounced) button reads released → RUN.
  - OVER: `game_over = 1`; `press` → RUN with `score`, `round` and level cleared.
- Speed ladder, with `clk_speed` as a registered decode of level:
  - Level 0 → 3'd2 (2 s/tick).
  - Level 1 → 3'd1 (1 s/tick).
  - Level 2 → 3'd4 (0.1 s/tick).
  - Codes 3'd0 and 3'd3 are never driven.
- `press` is ignored in JUDGE and COOLDOWN.
- A held button never re-triggers without a release.
- `score` and `round` never exceed `ROUNDS`; no wrap.

## Timing
- Reset values, all applied at the first rising edge with `reset` high, from any state:
  - state IDLE, level 0, `clk_speed` 3'd2.
  - `captured`, `score` and `round` 0.
  - `hit`, `miss` and `game_over` 0.
  - Synchronizer flops reset to 1 (released).
- Button latency: `catch_n` low setup before edge E−2 gives `press` high during the cycle ending at E0.
- Edge E0 (RUN): `captured` samples `current_number` present at E0.
- Edge E1: `hit`/`miss`, `score`, `round` and `clk_speed` update; `hit`/`miss` are high for exactly the E1..E2 cycle.
- Final round: `game_over` rises at E1.
- `current_number` changing in the same cycle as `press`: the value at the E0 edge is the one caught; no extra hold.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `NUMBER_CATCHER_DEBOUNCE_EN` defined:
  - Synchronized level must hold stable for `DEBOUNCE_CYCLES` consecutive cycles before the debounced level changes.
  - `press` comes from the debounced level; press latency grows by `DEBOUNCE_CYCLES`.
  - The debounce counter resets to 0.
- Undefined: no debounce counter; `press` comes directly from the synchronized level; `DEBOUNCE_CYCLES` is unused.

## Structure
- Package `number_catcher_pkg`:
  - FSM state enum (IDLE, RUN, JUDGE, COOLDOWN, OVER).
  - Level-to-`clk_speed` constants `SPEED_L0`=3'd2, `SPEED_L1`=3'd1, `SPEED_L2`=3'd4.
  - `MAX_LEVEL`=2.
- Sub-module `catch_input`:
  - Synchronizer, optional debounce and falling-edge detect.
  - Ports: `CLOCK_50`, `reset`, `catch_n` → `press`, `released`.

## Test plan
- Exact hit: reset, press (IDLE→RUN); target 40, `current_number` 40, press → `captured` 40, `hit` pulse 1 cycle, `score` 1, `clk_speed` 3'd1.
- Tolerance edges: target 40; catch 42 → hit; catch 43 → miss, `score` unchanged, `clk_speed` unchanged.
- Clamp / no wrap: target 120 (clamps to 100), catch 99 → hit; target 1, catch 100 → miss.
- Held button: hold `catch_n` low across JUDGE and COOLDOWN → exactly one capture; release then press → next capture.
- Game end: 8 rounds of hits → `score` 8, `round` 8, `game_over` 1, `clk_speed` saturates at 3'd4; press → RUN with `score`, `round` 0 and `clk_speed` 3'd2.
- Reset mid-JUDGE: assert `reset` on the JUDGE cycle → no `hit`/`miss` pulse; all outputs at reset values next edge.

Source files
------------

// File: rtl/number_catcher_pkg.sv
// Shared types and constants for the number_catcher game controller:
// FSM state encoding, speed-ladder codes and the top speed level.
package number_catcher_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        JUDGE    = 3'd2,
        COOLDOWN = 3'd3,
        OVER     = 3'd4
    } state_t;

    localparam logic [2:0] SPEED_L0  = 3'd2;
    localparam logic [2:0] SPEED_L1  = 3'd1;
    localparam logic [2:0] SPEED_L2  = 3'd4;
    localparam logic [1:0] MAX_LEVEL = 2'd2;

endpackage

// File: rtl/number_catcher_catch_input.sv
// Button front end: 2-flop synchronizer, optional debounce and falling-edge
// press detect. Debounce is built only with NUMBER_CATCHER_DEBOUNCE_EN defined.
module catch_input #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic catch_n,
    output logic press,
    output logic released
);

    logic sync_p0;
    logic sync_p1;
    logic level;
    logic level_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= catch_n;
            sync_p1 <= sync_p0;
        end
    end

`ifdef NUMBER_CATCHER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt;
    logic             db_level;

    // The debounced level follows the synchronized one only after it has
    // disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            db_cnt   <= '0;
            db_level <= 1'b1;
        end else if (sync_p1 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= sync_p1;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^32'(DEBOUNCE_CYCLES);
    assign level = sync_p1;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign press    = level_q & ~level;
    assign released = level;

endmodule

// File: rtl/number_catcher.sv
// Catch-the-number game controller: judges caught counter values against a
// clamped target, scores rounds and drives the counter speed select.
module number_catcher
    import number_catcher_pkg::*;
#(
    parameter int NUM_W           = 7,
    parameter int MAX_NUM         = 100,
    parameter int TOL             = 2,
    parameter int ROUNDS          = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             catch_n,
    input  logic [NUM_W-1:0] target,
    input  logic [NUM_W-1:0] current_number,
    output logic [2:0]       clk_speed,
    output logic [NUM_W-1:0] captured,
    output logic [3:0]       score,
    output logic [3:0]       round,
    output logic             hit,
    output logic             miss,
    output logic             game_over
);

    localparam logic [3:0] ROUNDS_4 = 4'(ROUNDS);

    function automatic logic [NUM_W-1:0] clamp_target(input logic [NUM_W-1:0] t);
        return (t > NUM_W'(MAX_NUM)) ? NUM_W'(MAX_NUM) : t;
    endfunction

    function automatic logic [NUM_W-1:0] abs_dist(input logic [NUM_W-1:0] a,
                                                  input logic [NUM_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [1:0] level_up(input logic [1:0] lv);
        return (lv >= MAX_LEVEL) ? MAX_LEVEL : lv + 2'd1;
    endfunction

    function automatic logic [2:0] speed_of(input logic [1:0] lv);
        case (lv)
            2'd0:    return SPEED_L0;
            2'd1:    return SPEED_L1;
            default: return SPEED_L2;
        endcase
    endfunction

    logic             press;
    logic             released;
    state_t           state;
    logic [NUM_W-1:0] tgt_q;
    logic [1:0]       level;
    logic             is_hit;
    logic [3:0]       round_nx;

    catch_input #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_catch_input (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .catch_n (catch_n),
        .press   (press),
        .released(released)
    );

    always_comb begin
        is_hit   = abs_dist(captured, tgt_q) <= NUM_W'(TOL);
        round_nx = (round < ROUNDS_4) ? round + 4'd1 : round;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            level     <= 2'd0;
            clk_speed <= SPEED_L0;
            captured  <= '0;
            tgt_q     <= '0;
            score     <= 4'd0;
            round     <= 4'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (press) begin
                        score     <= 4'd0;
                        round     <= 4'd0;
                        level     <= 2'd0;
                        clk_speed <= SPEED_L0;
                        game_over <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (press) begin
                        captured <= current_number;
                        tgt_q    <= clamp_target(target);
                        state    <= JUDGE;
                    end
                end
                JUDGE: begin
                    round <= round_nx;
                    if (is_hit) begin
                        hit       <= 1'b1;
                        score     <= (score < ROUNDS_4) ? score + 4'd1 : score;
                        level     <= level_up(level);
                        clk_speed <= speed_of(level_up(level));
                    end else begin
                        miss <= 1'b1;
                    end
                    if (round_nx == ROUNDS_4) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (released) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_number_catcher.sv
// Self-checking bench for number_catcher: directed scenarios plus randomized
// games checked against an arithmetic model of the game rules.
module tb_number_catcher;

    localparam int NUM_W   = 7;
    localparam int MAX_NUM = 100;
    localparam int TOL     = 2;
    localparam int ROUNDS  = 8;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic             catch_n;
    logic [NUM_W-1:0] target;
    logic [NUM_W-1:0] current_number;
    logic [2:0]       clk_speed;
    logic [NUM_W-1:0] captured;
    logic [3:0]       score;
    logic [3:0]       round;
    logic             hit;
    logic             miss;
    logic             game_over;

    number_catcher #(
        .NUM_W(NUM_W), .MAX_NUM(MAX_NUM), .TOL(TOL), .ROUNDS(ROUNDS), .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .catch_n       (catch_n),
        .target        (target),
        .current_number(current_number),
        .clk_speed     (clk_speed),
        .captured      (captured),
        .score         (score),
        .round         (round),
        .hit           (hit),
        .miss          (miss),
        .game_over     (game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests_run    = 0;
    int tests_failed = 0;

    // Game model
    int m_score;
    int m_round;
    int m_level;
    bit m_over;

    function automatic int exp_speed(input int lv);
        if (lv == 0) return 2;
        if (lv == 1) return 1;
        return 4;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_clear();
        m_score = 0;
        m_round = 0;
        m_level = 0;
        m_over  = 0;
    endtask

    task automatic model_judge(input int num, input int tgt, output bit h);
        int t;
        int d;
        t = (tgt > MAX_NUM) ? MAX_NUM : tgt;
        d = (num > t) ? num - t : t - num;
        h = (d <= TOL);
        if (h) begin
            m_score++;
            if (m_level < 2) m_level++;
        end
        m_round++;
        m_over = (m_round == ROUNDS);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        catch_n = 1'b1;
        tick(2);
        reset = 1'b0;
        model_clear();
        tick(1);
    endtask

    // Press from IDLE or OVER: counters and speed must clear at the press edge.
    task automatic start_game(input string tag);
        catch_n = 1'b0;
        tick(3);
        model_clear();
        tests_run++;
        if (score !== 4'd0 || round !== 4'd0 || clk_speed !== 3'd2 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_start: score=%0d round=%0d speed=%0d over=%0d, want 0 0 2 0",
                     tag, score, round, clk_speed, game_over);
        end
        catch_n = 1'b1;
        tick(4);
    endtask

    // One full round in RUN; current_number changes right before the capture edge.
    task automatic catch_round(input int num, input int tgt, input string tag);
        bit h;
        int decoy;
        decoy = (num + 37) % 101;
        current_number = NUM_W'(decoy);
        target = NUM_W'(tgt);
        catch_n = 1'b0;
        tick(2);
        current_number = NUM_W'(num);
        tick(1);
        tests_run++;
        if (captured !== NUM_W'(num) || hit !== 1'b0 || miss !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_capture: captured=%0d hit=%0d miss=%0d, want %0d 0 0",
                     tag, captured, hit, miss, num);
        end
        current_number = NUM_W'(decoy);
        tick(1);
        model_judge(num, tgt, h);
        tests_run++;
        if (hit !== h || miss !== !h || score !== 4'(m_score) || round !== 4'(m_round)
            || clk_speed !== 3'(exp_speed(m_level)) || game_over !== m_over) begin
            tests_failed++;
            $display("FAIL %s_judge: hit=%0d miss=%0d score=%0d round=%0d speed=%0d over=%0d, want %0d %0d %0d %0d %0d %0d",
                     tag, hit, miss, score, round, clk_speed, game_over,
                     h, !h, m_score, m_round, exp_speed(m_level), m_over);
        end
        tick(1);
        tests_run++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_pulse_width: hit=%0d miss=%0d, want 0 0", tag, hit, miss);
        end
        catch_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        target = '0;
        current_number = '0;
        apply_reset();
        tests_run++;
        if (clk_speed !== 3'd2 || captured !== '0 || score !== 4'd0 || round !== 4'd0
            || hit !== 1'b0 || miss !== 1'b0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: speed=%0d cap=%0d score=%0d round=%0d hit=%0d miss=%0d over=%0d, want 2 0 0 0 0 0 0",
                     clk_speed, captured, score, round, hit, miss, game_over);
        end
    endtask

    task automatic test_exact_hit();
        start_game("exact");
        catch_round(40, 40, "exact_hit");
    endtask

    task automatic test_tolerance();
        catch_round(42, 40, "tol_plus2");
        catch_round(43, 40, "tol_plus3");
        catch_round(38, 40, "tol_minus2");
        catch_round(37, 40, "tol_minus3");
    endtask

    task automatic test_clamp();
        catch_round(99, 120, "clamp_high");
        catch_round(100, 1, "no_wrap");
        catch_round(0, 100, "no_wrap_final");
    endtask

    task automatic test_held_button();
        bit h;
        bit pulsed;
        start_game("held");
        current_number = 7'd55;
        target = 7'd55;
        catch_n = 1'b0;
        tick(4);
        model_judge(55, 55, h);
        current_number = 7'd10;
        pulsed = 0;
        repeat (20) begin
            tick(1);
            if (hit || miss) pulsed = 1;
        end
        tests_run++;
        if (captured !== 7'd55 || round !== 4'(m_round) || score !== 4'(m_score) || pulsed) begin
            tests_failed++;
            $display("FAIL held_single_capture: cap=%0d round=%0d score=%0d extra_pulse=%0d, want 55 %0d %0d 0",
                     captured, round, score, pulsed, m_round, m_score);
        end
        catch_n = 1'b1;
        tick(4);
        catch_round(10, 12, "held_next");
    endtask

    task automatic test_game_end();
        int n;
        apply_reset();
        start_game("end");
        for (int i = 0; i < ROUNDS; i++) begin
            n = $urandom_range(0, MAX_NUM);
            catch_round(n, n, "end_round");
        end
        tests_run++;
        if (score !== 4'd8 || round !== 4'd8 || game_over !== 1'b1 || clk_speed !== 3'd4) begin
            tests_failed++;
            $display("FAIL game_end: score=%0d round=%0d over=%0d speed=%0d, want 8 8 1 4",
                     score, round, game_over, clk_speed);
        end
        start_game("restart");
    endtask

    task automatic test_random_games();
        int tgt;
        int t;
        int num;
        for (int i = 0; i < 3 * ROUNDS; i++) begin
            if (m_over) start_game("rand");
            tgt = $urandom_range(0, 127);
            t = (tgt > MAX_NUM) ? MAX_NUM : tgt;
            if ($urandom_range(0, 3) == 0) begin
                num = $urandom_range(0, MAX_NUM);
            end else begin
                num = t + $urandom_range(0, 8) - 4;
                if (num < 0) num = 0;
                if (num > MAX_NUM) num = MAX_NUM;
            end
            catch_round(num, tgt, "rand");
        end
    endtask

    task automatic test_reset_mid_judge();
        apply_reset();
        start_game("midjudge");
        current_number = 7'd30;
        target = 7'd30;
        catch_n = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        tests_run++;
        if (hit !== 1'b0 || miss !== 1'b0 || score !== 4'd0 || round !== 4'd0
            || clk_speed !== 3'd2 || captured !== '0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_judge: hit=%0d miss=%0d score=%0d round=%0d speed=%0d cap=%0d over=%0d, want all reset",
                     hit, miss, score, round, clk_speed, captured, game_over);
        end
        reset = 1'b0;
        catch_n = 1'b1;
        model_clear();
        tick(4);
    endtask

    initial begin
        reset = 1'b1;
        catch_n = 1'b1;
        target = '0;
        current_number = '0;
        test_reset();
        test_exact_hit();
        test_tolerance();
        test_clamp();
        test_held_button();
        test_game_end();
        test_random_games();
        test_reset_mid_judge();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
